// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the single-line serial frame link.
// Used by serial_frame_tx (optional parity via SERIAL_FRAME_TX_PARITY_EN).
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Clock cycles from the first START cycle to the last STOP cycle inclusive.
  function automatic int frame_len(input int data_w, input int clks_per_bit, input int p);
    return (2 + data_w + p) * clks_per_bit;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit down-counter: holds each line bit for CLKS_PER_BIT cycles.
// Shared between the transmitter and receiver of the serial link.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Load wins over counting, so a bit boundary always reloads and the
  // counter never wraps mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_end = en && (cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framed transmitter: start, LSB-first data, optional even
// parity (SERIAL_FRAME_TX_PARITY_EN), stop. Back-to-back frames accepted in last STOP cycle.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  // Handshake: a word transfers on a rising edge where valid_in && ready_out;
  // ready_out comes from registered state only, valid_in may toggle freely
  // while ready_out is low and data_in is ignored outside the transfer edge.

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [BCW-1:0]    bit_cnt;
  logic              bit_end;
  logic              accept;
  logic              timer_load;
  logic              timer_en;

  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_end;
  assign ready_out  = (state == IDLE) || frame_done;
  assign accept     = valid_in && ready_out;
  assign timer_en   = busy;
  assign timer_load = accept || bit_end;
  assign shift_next = shift_reg >> 1;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic [DATA_W-1:0] word;
  logic              parity_bit;

  // The shift register is consumed bit by bit, so keep the accepted word
  // intact for the parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (accept) begin
      word <= data_in;
    end
  end

  assign parity_bit = ^word;
`endif

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx_out    <= LINE_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            shift_reg <= data_in;
            bit_cnt   <= '0;
            tx_out    <= START_LVL;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            tx_out <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= parity_bit;
`else
              state  <= STOP;
              tx_out <= LINE_IDLE;
`endif
            end else begin
              shift_reg <= shift_next;
              tx_out    <= shift_next[0];
            end
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            tx_out <= LINE_IDLE;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (accept) begin
              state     <= START;
              shift_reg <= data_in;
              bit_cnt   <= '0;
              tx_out    <= START_LVL;
            end else begin
              state  <= IDLE;
              tx_out <= LINE_IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule
